// File: rtl/dp_cmp_seq.sv
// Multi-cycle magnitude comparator: walks two latched operands MS slice first,
// stops at the first unequal slice and reports EQ/GT/LT with a DONE strobe.

// One SLICE-bit compare lane. TOP marks the most significant slice, which is
// the only lane that honours two's-complement mode (sign bit inverted so an
// unsigned compare yields the signed ordering).
module dp_cmp_slice #(
  parameter int SLICE = 8,
  parameter bit TOP   = 1'b0
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_signed,
  output logic             o_gt,
  output logic             o_lt
);
  logic             w_flip;
  logic [SLICE-1:0] w_ax;
  logic [SLICE-1:0] w_bx;

  assign w_flip = TOP & i_signed;
  assign w_ax   = {i_a[SLICE-1] ^ w_flip, i_a[SLICE-2:0]};
  assign w_bx   = {i_b[SLICE-1] ^ w_flip, i_b[SLICE-2:0]};
  assign o_gt   = (w_ax > w_bx);
  assign o_lt   = (w_ax < w_bx);
endmodule

module dp_cmp_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8,
  parameter int IDXW  = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_clear,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_eq,
  output logic             o_gt,
  output logic             o_lt,
  output logic [IDXW-1:0]  o_slice_idx
);
  localparam int NSLICE = WIDTH / SLICE;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t            r_st, w_st_nxt;
  logic [WIDTH-1:0]  r_a, r_b;
  logic              r_sgn;
  logic [IDXW-1:0]   r_idx;
  logic              r_eq, r_gt, r_lt;

  logic [NSLICE-1:0] w_sl_gt, w_sl_lt;
  logic              w_gt, w_lt;
  logic              w_accept, w_set_eq, w_set_gt, w_set_lt, w_dec;

  // All slices compare in parallel; the sequencer just picks the current one.
  for (genvar g = 0; g < NSLICE; g++) begin : g_slc
    dp_cmp_slice #(.SLICE(SLICE), .TOP(g == NSLICE-1)) u_slc (
      .i_a      (r_a[g*SLICE +: SLICE]),
      .i_b      (r_b[g*SLICE +: SLICE]),
      .i_signed (r_sgn),
      .o_gt     (w_sl_gt[g]),
      .o_lt     (w_sl_lt[g])
    );
  end

  assign w_gt = w_sl_gt[r_idx];
  assign w_lt = w_sl_lt[r_idx];

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_st <= S_IDLE;
    else          r_st <= w_st_nxt;
  end

  // Next state and datapath strobes; CLEAR outranks both START and the slice result.
  always_comb begin
    w_st_nxt = r_st;
    w_accept = 1'b0;
    w_set_eq = 1'b0;
    w_set_gt = 1'b0;
    w_set_lt = 1'b0;
    w_dec    = 1'b0;
    case (r_st)
      S_IDLE: begin
        if (i_start && !i_clear) begin
          w_accept = 1'b1;
          w_st_nxt = S_RUN;
        end
      end
      S_FIN: begin
        if (i_start && !i_clear) begin
          w_accept = 1'b1;
          w_st_nxt = S_RUN;
        end else begin
          w_st_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (i_clear) begin
          w_st_nxt = S_IDLE;
        end else if (w_gt) begin
          w_set_gt = 1'b1;
          w_st_nxt = S_FIN;
        end else if (w_lt) begin
          w_set_lt = 1'b1;
          w_st_nxt = S_FIN;
        end else if (r_idx == '0) begin
          w_set_eq = 1'b1;
          w_st_nxt = S_FIN;
        end else begin
          w_dec = 1'b1;
        end
      end
      default: w_st_nxt = S_IDLE;
    endcase
  end

  // Operand/mode latch: only an accepted START loads new values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_sgn <= 1'b0;
    end else if (w_accept) begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_sgn <= i_signed;
    end
  end

  // Slice index walks down from the top slice while slices match.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_idx <= '0;
    else if (w_accept) r_idx <= IDXW'(NSLICE-1);
    else if (w_dec)    r_idx <= r_idx - IDXW'(1);
  end

  // Result flags: cleared on acceptance, then set once and held.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_eq <= 1'b0;
      r_gt <= 1'b0;
      r_lt <= 1'b0;
    end else if (w_accept) begin
      r_eq <= 1'b0;
      r_gt <= 1'b0;
      r_lt <= 1'b0;
    end else begin
      if (w_set_eq) r_eq <= 1'b1;
      if (w_set_gt) r_gt <= 1'b1;
      if (w_set_lt) r_lt <= 1'b1;
    end
  end

  assign o_busy      = (r_st == S_RUN);
  assign o_done      = (r_st == S_FIN);
  assign o_eq        = r_eq;
  assign o_gt        = r_gt;
  assign o_lt        = r_lt;
  assign o_slice_idx = r_idx;
endmodule
